// File: rtl/pe_pkg.sv
// Lane constants and drain FSM encoding shared by the psum requant output stage.
package pe_pkg;
    localparam int ARRAY_DIM = 16;
    localparam int ACC_WIDTH = 32;
    localparam int OUT_WIDTH = 8;
    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_FIN   = 2'd3
    } state_t;
endpackage

// File: rtl/requant_lane.sv
// One lane of requantization: bias add, round-half-up arithmetic shift, optional ReLU, int8 saturate.
// Latency: combinational. Backpressure: none.
// Width: sum needs 33 bits, rounding increment can push it one more, hence ACC_WIDTH+2.
module requant_lane
    import pe_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] psum,
    input  logic [ACC_WIDTH-1:0] bias,
    input  logic [4:0]           shift,
    input  logic                 relu_en,
    output logic [OUT_WIDTH-1:0] q
);
    localparam int SW = ACC_WIDTH + 2;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] res;

    always_comb begin
        sum = $signed({{2{psum[ACC_WIDTH-1]}}, psum}) + $signed({{2{bias[ACC_WIDTH-1]}}, bias});
        rnd = sum;
        if (shift != 5'd0) rnd = sum + (SW'(1) <<< (shift - 5'd1));
        res = rnd >>> shift;
        if (relu_en && (res < 0)) res = '0;
        q = res[OUT_WIDTH-1:0];
        if (res > SW'(INT8_MAX))      q = OUT_WIDTH'(INT8_MAX);
        else if (res < SW'(INT8_MIN)) q = OUT_WIDTH'(INT8_MIN);
    end
endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head is presented combinationally from storage.
// Latency: push visible at the head the cycle after the write.
// Backpressure: none internally; the writer must respect count (no overflow guard).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rptr];
    assign pop    = rd_vld & rd_rdy;

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_vld) wptr <= wptr + AW'(1);
            if (pop)    rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(wr_vld) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/psum_requant_drain.sv
// Drains psum BRAM words through per-lane requantization into a packed int8 output stream.
// Latency: start -> first read 1 cycle, read -> out_valid RD_LATENCY+1 cycles; 1 beat/cycle sustained.
// Backpressure: reads are credit-gated on FIFO occupancy plus in-flight reads; out_ready low stalls reads.
module psum_requant_drain
    import pe_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            num_words,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [4:0]                     shift,
    input  logic                           relu_en,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] bias,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_WIDTH-1:0]          psum_raddr,
    output logic                           psum_ren,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] psum_rdata,
    output logic [ARRAY_DIM*OUT_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]          out_addr,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(RD_LATENCY + 1);

    typedef struct packed {
        logic                           last;
        logic [ADDR_WIDTH-1:0]          addr;
        logic [ARRAY_DIM*OUT_WIDTH-1:0] data;
    } beat_t;

    state_t                         state;
    logic [ADDR_WIDTH:0]            n_words_q;
    logic [ADDR_WIDTH-1:0]          base_q;
    logic [4:0]                     shift_q;
    logic                           relu_q;
    logic [ARRAY_DIM*ACC_WIDTH-1:0] bias_q;
    logic [ADDR_WIDTH:0]            issued;
    logic [ADDR_WIDTH:0]            wr_idx;
    logic [RD_LATENCY-1:0]          pipe;
    logic [IW-1:0]                  inflight;
    logic [CW-1:0]                  fifo_count;
    logic                           ret_vld;
    logic                           credit_ok;
    logic                           last_acc;
    logic [ARRAY_DIM*OUT_WIDTH-1:0] lane_q;
    beat_t                          wr_beat;
    beat_t                          head;

    assign credit_ok  = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign psum_ren   = (state == ST_RUN) && (issued < n_words_q) && credit_ok;
    assign psum_raddr = base_q + issued[ADDR_WIDTH-1:0];
    assign ret_vld    = pipe[RD_LATENCY-1];

    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
        requant_lane u_lane (
            .psum    (psum_rdata[i*ACC_WIDTH +: ACC_WIDTH]),
            .bias    (bias_q[i*ACC_WIDTH +: ACC_WIDTH]),
            .shift   (shift_q),
            .relu_en (relu_q),
            .q       (lane_q[i*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // Returns arrive in issue order, so a write counter recovers the beat index.
    assign wr_beat.data = lane_q;
    assign wr_beat.addr = wr_idx[ADDR_WIDTH-1:0];
    assign wr_beat.last = (wr_idx == n_words_q - (ADDR_WIDTH+1)'(1));

    sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (ret_vld),
        .wr_dat (wr_beat),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat (head),
        .count  (fifo_count)
    );

    assign out_data = out_valid ? head.data : '0;
    assign out_addr = out_valid ? head.addr : '0;
    assign out_last = out_valid & head.last;
    assign last_acc = out_valid & out_ready & head.last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            n_words_q <= '0;
            base_q    <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            bias_q    <= '0;
            issued    <= '0;
            wr_idx    <= '0;
            pipe      <= '0;
            inflight  <= '0;
        end else begin
            done     <= 1'b0;
            pipe     <= (pipe << 1) | RD_LATENCY'(psum_ren);
            inflight <= inflight + IW'(psum_ren) - IW'(ret_vld);
            if (psum_ren) issued <= issued + (ADDR_WIDTH+1)'(1);
            if (ret_vld)  wr_idx <= wr_idx + (ADDR_WIDTH+1)'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_words_q <= num_words;
                        base_q    <= base_addr;
                        shift_q   <= shift;
                        relu_q    <= relu_en;
                        bias_q    <= bias;
                        issued    <= '0;
                        wr_idx    <= '0;
                        if (num_words == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (psum_ren && (issued + (ADDR_WIDTH+1)'(1) == n_words_q)) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if ((inflight == '0) && last_acc) begin
                        state <= ST_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_requant_drain.sv
// Directed bench for psum_requant_drain: BRAM model, handshake monitor, hand-computed expectations.
module tb_psum_requant_drain;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [10:0]  num_words;
    logic [9:0]   base_addr;
    logic [4:0]   shift;
    logic         relu_en;
    logic [511:0] bias;
    logic         busy;
    logic         done;
    logic [9:0]   psum_raddr;
    logic         psum_ren;
    logic [511:0] psum_rdata;
    logic [127:0] out_data;
    logic [9:0]   out_addr;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    psum_requant_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .base_addr  (base_addr),
        .shift      (shift),
        .relu_en    (relu_en),
        .bias       (bias),
        .busy       (busy),
        .done       (done),
        .psum_raddr (psum_raddr),
        .psum_ren   (psum_ren),
        .psum_rdata (psum_rdata),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    logic [511:0] mem [1024];
    always @(posedge clk) if (psum_ren) psum_rdata <= mem[psum_raddr];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0]   ren_addrs[$];
    logic [127:0] b_data[$];
    logic [9:0]   b_addr[$];
    logic         b_last[$];
    int first_ren, first_vld, last_cyc, done_cyc, done_cnt, start_cyc;

    always @(negedge clk) begin
        if (psum_ren) begin
            ren_addrs.push_back(psum_raddr);
            if (first_ren < 0) first_ren = cyc;
        end
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (out_valid && out_ready) begin
            b_data.push_back(out_data);
            b_addr.push_back(out_addr);
            b_last.push_back(out_last);
            if (out_last) last_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane_of(input logic [127:0] d, input int l);
        logic signed [7:0] v;
        v = d[l*8 +: 8];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_psum(input int addr, input int lane, input int val);
        mem[addr][lane*32 +: 32] = val;
    endtask

    task automatic job_clear();
        ren_addrs.delete();
        b_data.delete();
        b_addr.delete();
        b_last.delete();
        first_ren = -1;
        first_vld = -1;
        last_cyc  = -1;
        done_cyc  = -1;
        done_cnt  = 0;
    endtask

    task automatic do_start(input int nw, input int base, input int sh, input bit relu, input int b0);
        job_clear();
        num_words  = 11'(nw);
        base_addr  = 10'(base);
        shift      = 5'(sh);
        relu_en    = relu;
        bias       = '0;
        bias[31:0] = b0;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        repeat (2) tick();
        chk(tag, done_cnt, 1);
    endtask

    initial begin
        logic [127:0] d1;
        logic [7:0]   mask;
        rst = 1'b1; start = 1'b0; num_words = '0; base_addr = '0; shift = '0;
        relu_en = 1'b0; bias = '0; out_ready = 1'b1; psum_rdata = '0;
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        job_clear();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ren", psum_ren, 0);
        chk("rst_data", out_data[63:0], 0);
        rst = 1'b0;
        tick();

        // Wrap and saturation
        set_psum(10'h3FE, 0, 5);    set_psum(10'h3FE, 15, 1000);
        set_psum(10'h3FF, 0, -3);   set_psum(10'h3FF, 15, -1000);
        set_psum(10'h000, 0, 200);  set_psum(10'h000, 15, 0);
        set_psum(10'h001, 0, -200); set_psum(10'h001, 15, 127);
        do_start(4, 10'h3FE, 0, 0, 0);
        chk("t1_busy", busy, 1);
        wait_done("t1_done", 50);
        chk("t1_nren", ren_addrs.size(), 4);
        chk("t1_raddr0", ren_addrs[0], 10'h3FE);
        chk("t1_raddr1", ren_addrs[1], 10'h3FF);
        chk("t1_raddr2", ren_addrs[2], 10'h000);
        chk("t1_raddr3", ren_addrs[3], 10'h001);
        chk("t1_nbeat", b_data.size(), 4);
        chk("t1_l0_b0", lane_of(b_data[0], 0), 5);
        chk("t1_l0_b1", lane_of(b_data[1], 0), -3);
        chk("t1_l0_b2", lane_of(b_data[2], 0), 127);
        chk("t1_l0_b3", lane_of(b_data[3], 0), -128);
        chk("t1_l15_b0", lane_of(b_data[0], 15), 127);
        chk("t1_l15_b1", lane_of(b_data[1], 15), -128);
        chk("t1_l15_b3", lane_of(b_data[3], 15), 127);
        chk("t1_addr1", b_addr[1], 1);
        chk("t1_addr3", b_addr[3], 3);
        chk("t1_last", {b_last[0], b_last[1], b_last[2], b_last[3]}, 4'b0001);
        chk("t1_ren_lat", first_ren - start_cyc, 1);
        chk("t1_vld_lat", first_vld - start_cyc, 3);
        chk("t1_done_lat", done_cyc - last_cyc, 1);
        chk("t1_idle_busy", busy, 0);

        // Rounding
        set_psum(10'h010, 0, 7);
        set_psum(10'h011, 0, -7);
        do_start(2, 10'h010, 2, 0, 0);
        wait_done("t2a_done", 50);
        chk("t2_round_pos", lane_of(b_data[0], 0), 2);
        chk("t2_round_neg", lane_of(b_data[1], 0), -2);

        // ReLU with bias; the bias input changes after start and must not matter
        set_psum(10'h020, 0, -3);
        set_psum(10'h021, 0, -20);
        do_start(2, 10'h020, 0, 1, 10);
        bias = '0;
        wait_done("t2b_done", 50);
        chk("t2_relu_pos", lane_of(b_data[0], 0), 7);
        chk("t2_relu_clamp", lane_of(b_data[1], 0), 0);

        // Backpressure
        for (int i = 0; i < 8; i++) set_psum(10'h040 + i, 0, 3*i + 1);
        out_ready = 1'b0;
        do_start(8, 10'h040, 0, 0, 0);
        repeat (3) tick();
        d1 = out_data;
        repeat (6) tick();
        chk("t3_nren_stall", ren_addrs.size(), 4);
        chk("t3_ren_off", psum_ren, 0);
        chk("t3_busy", busy, 1);
        chk("t3_valid", out_valid, 1);
        chk("t3_head_addr", out_addr, 0);
        chk("t3_head_l0", lane_of(out_data, 0), 1);
        chk("t3_stable", out_data[63:0], d1[63:0]);
        out_ready = 1'b1;
        wait_done("t3_done", 80);
        chk("t3_nbeat", b_data.size(), 8);
        mask = '0;
        for (int i = 0; i < 8 && i < b_data.size(); i++) begin
            chk("t3_addr", b_addr[i], i);
            chk("t3_l0", lane_of(b_data[i], 0), 3*i + 1);
            mask[i] = b_last[i];
        end
        chk("t3_last_mask", mask, 8'h80);

        // Empty job
        do_start(0, 10'h100, 0, 0, 0);
        wait_done("t4_done", 20);
        chk("t4_done_lat", done_cyc - start_cyc, 1);
        chk("t4_nren", ren_addrs.size(), 0);
        chk("t4_nbeat", b_data.size(), 0);
        chk("t4_valid_seen", first_vld, -1);

        // Reset abort
        do_start(8, 10'h080, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_ren", psum_ren, 0);
        repeat (3) tick();
        chk("t5_no_done", done_cnt, 0);
        set_psum(10'h090, 0, 11);
        set_psum(10'h091, 0, 12);
        do_start(2, 10'h090, 0, 0, 0);
        wait_done("t5_done", 50);
        chk("t5_nbeat", b_data.size(), 2);
        chk("t5_l0_b0", lane_of(b_data[0], 0), 11);
        chk("t5_l0_b1", lane_of(b_data[1], 0), 12);
        chk("t5_last", {b_last[0], b_last[1]}, 2'b01);

        // Start while busy is ignored
        for (int i = 0; i < 4; i++) set_psum(10'h0A0 + i, 0, i + 1);
        set_psum(10'h0C0, 0, 99);
        do_start(4, 10'h0A0, 0, 0, 0);
        num_words = 11'd1;
        base_addr = 10'h0C0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_done", 50);
        chk("t6_nren", ren_addrs.size(), 4);
        chk("t6_raddr0", ren_addrs[0], 10'h0A0);
        chk("t6_raddr3", ren_addrs[3], 10'h0A3);
        chk("t6_nbeat", b_data.size(), 4);
        chk("t6_l0_b3", lane_of(b_data[3], 0), 4);
        chk("t6_last", b_last[3], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
